// File: rtl/cond_writeback_unit.sv
// Condition evaluation, NZCV flag register and write gating for the multi-cycle core.
// Sequences the two-beat register writeback of 64-bit multiply results.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | normal cycle: gated writes, flag update, low-word writeback
// S_HI    | second beat: write held high word to held RdHi, Busy=1
module cond_writeback_unit #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    Cond,
    input  logic [3:0]    ALUFlags,
    input  logic [1:0]    FlagW,
    input  logic          PCS,
    input  logic          NextPC,
    input  logic          RegW,
    input  logic          MemW,
    input  logic          NoWrite,
    input  logic          LongW,
    input  logic [DW-1:0] Result,
    input  logic [DW-1:0] ResultHi,
    input  logic [AW-1:0] RdLo,
    input  logic [AW-1:0] RdHi,
    output logic          PCWrite,
    output logic          RegWrite,
    output logic          MemWrite,
    output logic [AW-1:0] WB_Addr,
    output logic [DW-1:0] WB_Data,
    output logic [3:0]    Flags,
    output logic          CondEx,
    output logic          Busy
);

    typedef enum logic {S_IDLE, S_HI} state_t;

    state_t        state_q, state_d;
    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] hi_data_q, hi_data_d;
    logic [AW-1:0] hi_addr_q, hi_addr_d;

    logic n, z, c, v;

    assign {n, z, c, v} = flags_q;
    assign Flags = flags_q;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            4'b0000: CondEx = z;
            4'b0001: CondEx = ~z;
            4'b0010: CondEx = c;
            4'b0011: CondEx = ~c;
            4'b0100: CondEx = n;
            4'b0101: CondEx = ~n;
            4'b0110: CondEx = v;
            4'b0111: CondEx = ~v;
            4'b1000: CondEx = c & ~z;
            4'b1001: CondEx = ~c | z;
            4'b1010: CondEx = (n == v);
            4'b1011: CondEx = (n != v);
            4'b1100: CondEx = ~z & (n == v);
            4'b1101: CondEx = z | (n != v);
            4'b1110: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        flags_d   = flags_q;
        hi_data_d = hi_data_q;
        hi_addr_d = hi_addr_q;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemWrite  = 1'b0;
        WB_Addr   = '0;
        WB_Data   = '0;
        Busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                PCWrite  = (PCS & CondEx) | NextPC;
                MemWrite = MemW & CondEx;
                RegWrite = RegW & CondEx & ~NoWrite;
                WB_Addr  = RdLo;
                WB_Data  = Result;
                if (CondEx & FlagW[1]) flags_d[3:2] = ALUFlags[3:2];
                if (CondEx & FlagW[0]) flags_d[1:0] = ALUFlags[1:0];
                if (RegWrite & LongW) begin
                    hi_data_d = ResultHi;
                    hi_addr_d = RdHi;
                    state_d   = S_HI;
                end
            end
            S_HI: begin
                RegWrite = 1'b1;
                WB_Addr  = hi_addr_q;
                WB_Data  = hi_data_q;
                Busy     = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Reset also silences the write ports, including a pending high beat.
        if (reset) begin
            PCWrite  = 1'b0;
            RegWrite = 1'b0;
            MemWrite = 1'b0;
            WB_Addr  = '0;
            WB_Data  = '0;
            Busy     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            flags_q   <= 4'b0000;
            hi_data_q <= '0;
            hi_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            hi_data_q <= hi_data_d;
            hi_addr_q <= hi_addr_d;
        end
    end

endmodule

// File: tb/tb_cond_writeback_unit.sv
// Directed self-checking bench for cond_writeback_unit.
module tb_cond_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  Cond, ALUFlags;
    logic [1:0]  FlagW;
    logic        PCS, NextPC, RegW, MemW, NoWrite, LongW;
    logic [31:0] Result, ResultHi;
    logic [3:0]  RdLo, RdHi;
    logic        PCWrite, RegWrite, MemWrite, CondEx, Busy;
    logic [3:0]  WB_Addr, Flags;
    logic [31:0] WB_Data;

    int total  = 0;
    int passed = 0;

    cond_writeback_unit #(.DW(32), .AW(4)) dut (
        .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
        .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .NoWrite(NoWrite),
        .LongW(LongW), .Result(Result), .ResultHi(ResultHi), .RdLo(RdLo), .RdHi(RdHi),
        .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .WB_Addr(WB_Addr),
        .WB_Data(WB_Data), .Flags(Flags), .CondEx(CondEx), .Busy(Busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Cond = 4'b1110; ALUFlags = 4'b0000; FlagW = 2'b00;
        PCS = 0; NextPC = 0; RegW = 0; MemW = 0; NoWrite = 0; LongW = 0;
        Result = '0; ResultHi = '0; RdLo = '0; RdHi = '0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        RegW = 1; Result = 32'hAAAA5555; RdLo = 4'd2;
        tick();
        chk("rst_regwrite", RegWrite, 0);
        chk("rst_wbdata", WB_Data, 0);
        chk("rst_flags", Flags, 4'b0000);
        tick();
        reset = 1'b0;
        idle_inputs();

        // plain register write
        RegW = 1; RdLo = 4'd3; Result = 32'h12345678;
        #1;
        chk("t1_regwrite", RegWrite, 1);
        chk("t1_addr", WB_Addr, 3);
        chk("t1_data", WB_Data, 32'h12345678);
        chk("t1_busy", Busy, 0);
        chk("t1_flags", Flags, 4'b0000);
        tick();

        // flag write then EQ/NE
        idle_inputs();
        FlagW = 2'b11; ALUFlags = 4'b0110;
        tick();
        idle_inputs();
        Cond = 4'b0000; RegW = 1;
        #1;
        chk("t2_flags", Flags, 4'b0110);
        chk("t2_eq_condex", CondEx, 1);
        chk("t2_eq_regwrite", RegWrite, 1);
        Cond = 4'b0001;
        #1;
        chk("t2_ne_condex", CondEx, 0);
        chk("t2_ne_regwrite", RegWrite, 0);
        tick();

        // signed conditions with N=1, V=1
        idle_inputs();
        FlagW = 2'b11; ALUFlags = 4'b1001;
        tick();
        idle_inputs();
        #1;
        chk("t3_flags", Flags, 4'b1001);
        Cond = 4'b1010; #1; chk("t3_ge", CondEx, 1);
        Cond = 4'b1011; #1; chk("t3_lt", CondEx, 0);
        Cond = 4'b1100; #1; chk("t3_gt", CondEx, 1);
        Cond = 4'b1101; #1; chk("t3_le", CondEx, 0);
        Cond = 4'b1000; #1; chk("t3_hi", CondEx, 0);
        Cond = 4'b1111; #1; chk("t3_nv", CondEx, 0);
        tick();

        // long writeback, HI beat ignores inputs
        idle_inputs();
        RegW = 1; LongW = 1; RdLo = 4'd4; RdHi = 4'd5;
        Result = 32'h00000001; ResultHi = 32'hFFFFFFFF;
        #1;
        chk("t4_c0_regwrite", RegWrite, 1);
        chk("t4_c0_addr", WB_Addr, 4);
        chk("t4_c0_data", WB_Data, 32'h00000001);
        chk("t4_c0_busy", Busy, 0);
        tick();
        ResultHi = 32'hDEADBEEF; RdHi = 4'd9; FlagW = 2'b11; ALUFlags = 4'b0110;
        PCS = 1; MemW = 1;
        #1;
        chk("t4_c1_busy", Busy, 1);
        chk("t4_c1_regwrite", RegWrite, 1);
        chk("t4_c1_addr", WB_Addr, 5);
        chk("t4_c1_data", WB_Data, 32'hFFFFFFFF);
        chk("t4_c1_pcwrite", PCWrite, 0);
        chk("t4_c1_memwrite", MemWrite, 0);
        tick();
        idle_inputs();
        #1;
        chk("t4_c2_busy", Busy, 0);
        chk("t4_c2_flags", Flags, 4'b1001);

        // back-to-back long writeback in the cycle after HI
        RegW = 1; LongW = 1; RdLo = 4'd6; RdHi = 4'd6;
        Result = 32'h0000000A; ResultHi = 32'h0000000B;
        #1;
        chk("t5_c0_addr", WB_Addr, 6);
        chk("t5_c0_data", WB_Data, 32'h0000000A);
        tick();
        idle_inputs();
        #1;
        chk("t5_c1_busy", Busy, 1);
        chk("t5_c1_addr", WB_Addr, 6);
        chk("t5_c1_data", WB_Data, 32'h0000000B);
        tick();

        // reset during HI suppresses the high beat
        idle_inputs();
        RegW = 1; LongW = 1; RdLo = 4'd1; RdHi = 4'd9; ResultHi = 32'h55;
        tick();
        idle_inputs();
        reset = 1'b1;
        #1;
        chk("t6_rst_regwrite", RegWrite, 0);
        chk("t6_rst_busy", Busy, 0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_after_busy", Busy, 0);
        chk("t6_after_flags", Flags, 4'b0000);
        tick();

        // NoWrite blocks register write and HI beat, flags still update
        idle_inputs();
        NoWrite = 1; FlagW = 2'b11; ALUFlags = 4'b0100; RegW = 1; LongW = 1;
        #1;
        chk("t7_regwrite", RegWrite, 0);
        tick();
        idle_inputs();
        #1;
        chk("t7_busy", Busy, 0);
        chk("t7_flags", Flags, 4'b0100);
        chk("t7_regwrite_next", RegWrite, 0);

        // failing condition blocks long writeback (Z=1 so NE fails)
        Cond = 4'b0001; RegW = 1; LongW = 1; MemW = 1; PCS = 1;
        #1;
        chk("t8_regwrite", RegWrite, 0);
        chk("t8_memwrite", MemWrite, 0);
        chk("t8_pcwrite", PCWrite, 0);
        NextPC = 1;
        #1;
        chk("t8_nextpc", PCWrite, 1);
        tick();
        idle_inputs();
        #1;
        chk("t8_busy", Busy, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cond_writeback_unit.md
Name: cond_writeback_unit

Overview:
- Consumer end of the ALU result/flag interface in the multi-cycle core.
- Holds the architectural NZCV flag register and evaluates the 4-bit instruction condition against it.
- Gates PC, register and memory writes; sequences the two-beat register writeback of 64-bit SMUL/UMUL results (low word, then high word).
- Raises Busy so the main controller stalls during the second beat.

Parameters:
- DW, 32, data word width (Result, ResultHi, WB_Data)
- AW, 4, register-file address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- Cond  in  4  instruction condition field
- ALUFlags  in  4  {N,Z,C,V} from ALU, same cycle as Result
- FlagW  in  2  [1]=update N,Z; [0]=update C,V
- PCS  in  1  instruction writes PC (branch or Rd=PC)
- NextPC  in  1  controller unconditional PC advance
- RegW  in  1  controller register-write request
- MemW  in  1  controller memory-write request
- NoWrite  in  1  suppress register write (CMP/CMN/TST)
- LongW  in  1  64-bit writeback request (SMUL/UMUL)
- Result  in  DW  ALU low result
- ResultHi  in  DW  ALU high result
- RdLo  in  AW  destination for low word
- RdHi  in  AW  destination for high word
- PCWrite  out  1  PC enable
- RegWrite  out  1  register-file write enable
- MemWrite  out  1  memory write enable
- WB_Addr  out  AW  register-file write address
- WB_Data  out  DW  register-file write data
- Flags  out  4  current registered {N,Z,C,V}
- CondEx  out  1  condition-pass for the current instruction
- Busy  out  1  high during the second writeback beat

Behaviour:
- Reset: Flags=0000, state=IDLE, held Hi data/address=0. While reset is high, PCWrite, RegWrite, MemWrite and Busy are 0, WB_Addr=0 and WB_Data=0.
- CondEx is combinational from Cond and the registered Flags, before any same-cycle update.
- Condition decode:
  - 0000 EQ: Z; 0001 NE: ~Z
  - 0010 CS: C; 0011 CC: ~C
  - 0100 MI: N; 0101 PL: ~N
  - 0110 VS: V; 0111 VC: ~V
  - 1000 HI: C&~Z; 1001 LS: ~C|Z
  - 1010 GE: N==V; 1011 LT: N!=V
  - 1100 GT: ~Z&(N==V); 1101 LE: Z|(N!=V)
  - 1110 AL: 1; 1111: 0
- Flag update, at the clock edge, in IDLE only:
  - if CondEx&FlagW[1], Flags[3:2]<=ALUFlags[3:2]
  - if CondEx&FlagW[0], Flags[1:0]<=ALUFlags[1:0]
  - Flags is never updated in HI.
- State IDLE:
  - PCWrite = (PCS&CondEx)|NextPC
  - MemWrite = MemW&CondEx
  - RegWrite = RegW&CondEx&~NoWrite
  - WB_Addr = RdLo; WB_Data = Result; Busy = 0
  - If RegWrite&LongW: latch ResultHi and RdHi, go to HI. The low word is written this cycle.
  - A failing condition or NoWrite blocks the HI beat as well.
- State HI (exactly one cycle):
  - RegWrite=1, WB_Addr=held RdHi, WB_Data=held ResultHi, Busy=1
  - PCWrite=0, MemWrite=0
  - All inputs ignored. Next state IDLE unconditionally.
- Back-to-back long writebacks: a LongW request arriving in the IDLE cycle right after HI is accepted normally. No minimum gap is required beyond Busy.
- RdLo==RdHi: both beats write the same register, so the high word wins. No error is flagged.
- Reset asserted in HI: the high-word write is suppressed that cycle. Next state IDLE, held data cleared.
- Write ports are combinational from the state and the registered values. Total write latency is 0 cycles for the low word and 1 cycle for the high word.

Test Plan:
- Reset, then Cond=1110, RegW=1, RdLo=3, Result=0x12345678 -> same cycle RegWrite=1, WB_Addr=3, WB_Data=0x12345678, Busy=0, Flags=0000.
- FlagW=11, Cond=1110, ALUFlags=0110; next cycle Cond=0000 (EQ), RegW=1 -> Flags=0110, CondEx=1, RegWrite=1. Then Cond=0001 (NE) -> CondEx=0, RegWrite=0.
- Flags=1001 (N=1, V=1): Cond=1010 GE -> CondEx=1; 1011 LT -> 0; 1100 GT -> 1; 1101 LE -> 0. Cond=1111 -> CondEx=0 for any Flags.
- LongW=1, RegW=1, Cond=AL, RdLo=4, RdHi=5, Result=0x00000001, ResultHi=0xFFFFFFFF:
  - cycle0: RegWrite=1, WB_Addr=4, WB_Data=0x00000001
  - cycle1: Busy=1, RegWrite=1, WB_Addr=5, WB_Data=0xFFFFFFFF, with a changed ResultHi input ignored
  - cycle2: Busy=0
- In the same setup, drive FlagW=11, PCS=1, MemW=1 during the HI cycle -> PCWrite=0, MemWrite=0, Flags unchanged.
- Start a long writeback, assert reset in the HI cycle -> RegWrite=0 that cycle. Next cycle Busy=0 and Flags=0000.
- NoWrite=1, FlagW=11, Cond=AL, ALUFlags=0100 -> RegWrite=0, no HI beat even with LongW=1, Flags=0100 next cycle.
